ram_scan_buffer: RTL and testbench

Parametrised dual-port scratch memory with a self-advancing read scanner, for board-level data entry and display.
- A user write port is driven from switches and commits once per key press.
- The read port walks the address space in one of three modes: auto, hold, or manual step. It presents address and data for the hex display stage.
- On every reset the block clears its own memory before accepting traffic.

---
 rtl/ram_scan_pkg.sv | 15 +
 rtl/edge_sync.sv | 27 ++
 rtl/ram_scan_buffer.sv | 121 ++++++++++++
 tb/tb_ram_scan_buffer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_scan_pkg.sv
// Shared types for the scan buffer: read-scan modes and controller states.
package ram_scan_pkg;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'b00,
    MODE_HOLD   = 2'b01,
    MODE_MANUAL = 2'b10
  } scan_mode_t;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for a board-level level input, plus a one-cycle rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise_c
);

  logic sync_1;
  logic sync_2;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      prev   <= sync_2;
    end
  end

  assign rise_c = sync_2 & ~prev;

endmodule

// File: rtl/ram_scan_buffer.sv
// Dual-port scratch memory: key-press write port plus a self-advancing read scanner.
// The memory is cleared by the controller after every reset before traffic is accepted.
module ram_scan_buffer
  import ram_scan_pkg::*;
#(
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned SCAN_DIV = 33554432
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [1:0]        mode,
  input  logic              step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_done,
  output logic              busy
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned TICK_W = $clog2(SCAN_DIV);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [TICK_W-1:0] tick;

  logic wr_rise_c;
  logic step_rise_c;
  logic tick_wrap_c;
  logic adv_c;
  logic wr_en_c;

  edge_sync u_wr_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (wr_req),
    .rise_c (wr_rise_c)
  );

  edge_sync u_step_sync (
    .clk    (clk),
    .reset  (reset),
    .din    (step),
    .rise_c (step_rise_c)
  );

  // Scan advance and write enable; mode 2'b11 falls into the hold default.
  always_comb begin
    tick_wrap_c = (tick == TICK_W'(SCAN_DIV - 1));
    adv_c       = 1'b0;
    wr_en_c     = 1'b0;
    if (state == RUN) begin
      wr_en_c = wr_rise_c;
      case (mode)
        MODE_AUTO:   adv_c = tick_wrap_c;
        MODE_MANUAL: adv_c = step_rise_c;
        default:     adv_c = 1'b0;
      endcase
    end
  end

  // Memory has no reset; the CLEAR sweep owns the write port until RUN.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_en_c) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Controller: clear sweep, then scan and write handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CLEAR;
      ptr      <= '0;
      tick     <= '0;
      busy     <= 1'b1;
      rd_addr  <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      wr_done <= wr_en_c;
      case (state)
        CLEAR: begin
          ptr      <= ptr + ADDR_W'(1);
          tick     <= '0;
          rd_addr  <= '0;
          rd_data  <= '0;
          rd_valid <= 1'b0;
          if (ptr == ADDR_W'(DEPTH - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          busy <= 1'b0;
          // Counter only runs in auto, so re-entering auto waits a full period.
          if ((mode == MODE_AUTO) && !tick_wrap_c) begin
            tick <= tick + TICK_W'(1);
          end else begin
            tick <= '0;
          end
          if (adv_c) begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
          // Read-old on collision; valid drops for the cycle the address moves.
          rd_data  <= mem[rd_addr];
          rd_valid <= ~adv_c;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_scan_buffer.sv
// Directed self-checking bench for ram_scan_buffer (DATA_W=4, ADDR_W=5, SCAN_DIV=4).
module tb_ram_scan_buffer;

  localparam int unsigned DATA_W   = 4;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned SCAN_DIV = 4;

  logic              clk     = 1'b0;
  logic              reset   = 1'b0;
  logic              wr_req  = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [1:0]        mode    = 2'b10;
  logic              step    = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_done;
  logic              busy;

  int checks = 0;
  int errors = 0;

  ram_scan_buffer #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .mode     (mode),
    .step     (step),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_done  (wr_done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
    check({tag, "_rd_data"},  32'(rd_data),  32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_wr_done"},  32'(wr_done),  32'd0);
    check({tag, "_busy"},     32'(busy),     32'd1);
  endtask

  // Called on a falling edge; releases reset and measures the clear window.
  task automatic release_and_clear(input string tag);
    int n;
    int nd;
    n  = 0;
    nd = 0;
    reset = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      if (wr_done === 1'b1) nd++;
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'd32);
    check({tag, "_wr_done_in_clear"}, 32'(nd), 32'd0);
  endtask

  task automatic step_pulse();
    step = 1'b1;
    repeat (4) @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    repeat (3) @(negedge clk);
    check("write_wr_done", 32'(wr_done), 32'd1);
    wr_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    release_and_clear("init");

    // Manual sweep of the whole cleared memory
    @(negedge clk);
    check("run_rd_valid", 32'(rd_valid), 32'd1);
    check("run_rd_addr", 32'(rd_addr), 32'd0);
    for (int i = 0; i < 32; i++) begin
      step_pulse();
      check("sweep_addr", 32'(rd_addr), 32'((i + 1) % 32));
      check("sweep_data", 32'(rd_data), 32'd0);
      check("sweep_valid", 32'(rd_valid), 32'd1);
    end

    // Held write request produces a single write
    wr_addr = 5'd1;
    wr_data = 4'd5;
    wr_req  = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (wr_done === 1'b1) nd++;
    end
    wr_req = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (wr_done === 1'b1) nd++;
    end
    check("held_wr_done_pulses", 32'(nd), 32'd1);
    step_pulse();
    check("addr1_addr", 32'(rd_addr), 32'd1);
    check("addr1_data", 32'(rd_data), 32'd5);

    // Collision at the held read address
    step_pulse();
    check("addr2_data", 32'(rd_data), 32'd0);
    mode    = 2'b01;
    wr_addr = 5'd2;
    wr_data = 4'd9;
    wr_req  = 1'b1;
    repeat (3) @(negedge clk);
    check("collide_wr_done", 32'(wr_done), 32'd1);
    check("collide_old_data", 32'(rd_data), 32'd0);
    check("collide_valid", 32'(rd_valid), 32'd1);
    @(negedge clk);
    check("collide_new_data", 32'(rd_data), 32'd9);
    check("collide_valid_next", 32'(rd_valid), 32'd1);
    wr_req = 1'b0;
    repeat (3) @(negedge clk);
    write_word(5'd3, 4'd11);
    check("other_write_data", 32'(rd_data), 32'd9);
    check("other_write_addr", 32'(rd_addr), 32'd2);

    // Mode 11 behaves as hold, including step edges being ignored
    mode = 2'b11;
    step_pulse();
    check("mode11_addr", 32'(rd_addr), 32'd2);

    // Auto scan: step every 4 cycles with a one-cycle valid gap, wrapping 31 -> 0
    mode = 2'b00;
    for (int k = 1; k <= 140; k++) begin
      @(negedge clk);
      check("auto_addr", 32'(rd_addr), 32'((2 + k / 4) % 32));
      check("auto_valid", 32'(rd_valid), 32'((k % 4) != 0));
    end
    repeat (2) @(negedge clk);
    mode = 2'b01;
    repeat (2) @(negedge clk);
    check("hold_addr", 32'(rd_addr), 32'd5);
    mode = 2'b00;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      check("reauto_addr", 32'(rd_addr), (j == 4) ? 32'd6 : 32'd5);
    end

    // Write addr 6, then reset mid-scan
    mode = 2'b01;
    @(negedge clk);
    write_word(5'd6, 4'd7);
    check("addr6_before_reset", 32'(rd_data), 32'd7);
    mode = 2'b00;
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_values("mid");
    wr_addr = 5'd4;
    wr_data = 4'd13;
    wr_req  = 1'b1;
    mode    = 2'b10;
    @(negedge clk);
    release_and_clear("mid");
    wr_req = 1'b0;
    @(negedge clk);
    check("post_addr", 32'(rd_addr), 32'd0);
    check("post_valid", 32'(rd_valid), 32'd1);
    check("post_data", 32'(rd_data), 32'd0);
    repeat (4) step_pulse();
    check("clear_write_addr4", 32'(rd_addr), 32'd4);
    check("clear_write_data4", 32'(rd_data), 32'd0);
    repeat (2) step_pulse();
    check("reset_addr6", 32'(rd_addr), 32'd6);
    check("reset_data6", 32'(rd_data), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
